ras_ctrl: RTL and testbench

Return-address-stack controller for the fetch predictor. It owns the RAS_ENTRIES-deep circular stack of PC38 return targets and its stack pointer and occupancy count, and sequences push, pop and replace operations from BTB actions. It exposes the stack state for branch checkpointing into the BCB, and restores that state on a restart. It sits beside the BTB/PHT in the fetch-predict stage and supplies ret_pc38 to the next-PC mux.

---
 rtl/ras_ctrl.sv | 103 ++++++++++
 tb/tb_ras_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ras_ctrl.sv
// Return-address stack for the fetch predictor: a circular stack of PC38 targets
// with pointer/occupancy state that is checkpointed by the BCB and restored on restart.
module ras_ctrl #(
  parameter int RAS_ENTRIES     = 16,
  parameter int LOG_RAS_ENTRIES = 4
) (
  input  logic                       CLK,
  input  logic                       rst,
  input  logic                       req_valid,
  input  logic [2:0]                 req_action,
  input  logic [37:0]                req_link_pc38,
  input  logic                       stall,
  input  logic                       restart_valid,
  input  logic [LOG_RAS_ENTRIES-1:0] restart_ras_index,
  input  logic [LOG_RAS_ENTRIES:0]   restart_ras_count,
  output logic [37:0]                ret_pc38,
  output logic                       ret_valid,
  output logic [LOG_RAS_ENTRIES-1:0] ras_index,
  output logic [LOG_RAS_ENTRIES:0]   ras_count
);

  localparam logic [2:0] ACT_JUMP_L     = 3'b011;
  localparam logic [2:0] ACT_RET        = 3'b100;
  localparam logic [2:0] ACT_RET_L      = 3'b101;
  localparam logic [2:0] ACT_INDIRECT_L = 3'b111;

  localparam logic [LOG_RAS_ENTRIES-1:0] SP_ONE   = (LOG_RAS_ENTRIES)'(1);
  localparam logic [LOG_RAS_ENTRIES:0]   CNT_ONE  = (LOG_RAS_ENTRIES+1)'(1);
  localparam logic [LOG_RAS_ENTRIES:0]   CNT_ZERO = (LOG_RAS_ENTRIES+1)'(0);
  localparam logic [LOG_RAS_ENTRIES:0]   CNT_FULL = (LOG_RAS_ENTRIES+1)'(RAS_ENTRIES);

  logic [37:0]                stack_q [RAS_ENTRIES];
  logic [LOG_RAS_ENTRIES-1:0] sp_q, sp_d;
  logic [LOG_RAS_ENTRIES:0]   cnt_q, cnt_d;
  logic                       wr_en_d;
  logic [LOG_RAS_ENTRIES-1:0] wr_idx_d;

  // Next-state: restart beats the request; the request is dropped when stalled.
  always_comb begin
    sp_d     = sp_q;
    cnt_d    = cnt_q;
    wr_en_d  = 1'b0;
    wr_idx_d = sp_q;
    if (restart_valid) begin
      sp_d  = restart_ras_index;
      cnt_d = (restart_ras_count > CNT_FULL) ? CNT_FULL : restart_ras_count;
    end else if (req_valid && !stall) begin
      case (req_action)
        ACT_JUMP_L, ACT_INDIRECT_L: begin
          // Overflow silently overwrites the oldest entry; count saturates.
          sp_d     = sp_q + SP_ONE;
          wr_en_d  = 1'b1;
          wr_idx_d = sp_q + SP_ONE;
          cnt_d    = (cnt_q == CNT_FULL) ? CNT_FULL : cnt_q + CNT_ONE;
        end
        ACT_RET: begin
          if (cnt_q != CNT_ZERO) begin
            sp_d  = sp_q - SP_ONE;
            cnt_d = cnt_q - CNT_ONE;
          end else begin
            sp_d  = sp_q;
            cnt_d = cnt_q;
          end
        end
        ACT_RET_L: begin
          wr_en_d = 1'b1;
          cnt_d   = (cnt_q == CNT_ZERO) ? CNT_ONE : cnt_q;
        end
        default: begin
          sp_d  = sp_q;
          cnt_d = cnt_q;
        end
      endcase
    end else begin
      sp_d  = sp_q;
      cnt_d = cnt_q;
    end
  end

  // State registers and stack storage with synchronous reset.
  always_ff @(posedge CLK) begin
    if (rst) begin
      sp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        stack_q[i] <= 38'h0;
      end
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      if (wr_en_d) begin
        stack_q[wr_idx_d] <= req_link_pc38;
      end
    end
  end

  // Reads see pre-update state, so a RET/RET_L gets the old top in its own cycle.
  assign ret_pc38  = stack_q[sp_q];
  assign ret_valid = (cnt_q != CNT_ZERO);
  assign ras_index = sp_q;
  assign ras_count = cnt_q;

endmodule

// File: tb/tb_ras_ctrl.sv
// Self-checking bench for ras_ctrl: directed scenarios plus randomized traffic
// checked against an array-based stack model.
module tb_ras_ctrl;

  logic        CLK = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_action;
  logic [37:0] req_link_pc38;
  logic        stall;
  logic        restart_valid;
  logic [3:0]  restart_ras_index;
  logic [4:0]  restart_ras_count;
  logic [37:0] ret_pc38;
  logic        ret_valid;
  logic [3:0]  ras_index;
  logic [4:0]  ras_count;

  int checks = 0;
  int errors = 0;

  // Reference model: plain array, integer pointer and count.
  logic [37:0] m_stack [16];
  int          m_sp;
  int          m_cnt;

  ras_ctrl #(.RAS_ENTRIES(16), .LOG_RAS_ENTRIES(4)) dut (
    .CLK(CLK), .rst(rst), .req_valid(req_valid), .req_action(req_action),
    .req_link_pc38(req_link_pc38), .stall(stall), .restart_valid(restart_valid),
    .restart_ras_index(restart_ras_index), .restart_ras_count(restart_ras_count),
    .ret_pc38(ret_pc38), .ret_valid(ret_valid), .ras_index(ras_index), .ras_count(ras_count)
  );

  always #5 CLK = ~CLK;

  task automatic drive(input logic r, input logic v, input logic [2:0] a, input logic [37:0] link,
                       input logic st, input logic rv, input logic [3:0] ri, input logic [4:0] rc);
    rst = r; req_valid = v; req_action = a; req_link_pc38 = link;
    stall = st; restart_valid = rv; restart_ras_index = ri; restart_ras_count = rc;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 3'b000, 38'h0, 1'b0, 1'b0, 4'h0, 5'h0);
  endtask

  task automatic model_update();
    if (rst) begin
      for (int i = 0; i < 16; i++) m_stack[i] = 38'h0;
      m_sp = 0;
      m_cnt = 0;
    end else if (restart_valid) begin
      m_sp = int'(restart_ras_index);
      m_cnt = (int'(restart_ras_count) > 16) ? 16 : int'(restart_ras_count);
    end else if (req_valid && !stall) begin
      if (req_action == 3'b011 || req_action == 3'b111) begin
        m_sp = (m_sp + 1) % 16;
        m_stack[m_sp] = req_link_pc38;
        m_cnt = (m_cnt < 16) ? m_cnt + 1 : 16;
      end else if (req_action == 3'b100) begin
        if (m_cnt > 0) begin
          m_sp = (m_sp + 15) % 16;
          m_cnt = m_cnt - 1;
        end
      end else if (req_action == 3'b101) begin
        m_stack[m_sp] = req_link_pc38;
        if (m_cnt == 0) m_cnt = 1;
      end
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    model_update();
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 3'b000, 38'h0, 1'b0, 1'b0, 4'h0, 5'h0);
    step();
    idle();
  endtask

  task automatic push(input logic [37:0] link);
    drive(1'b0, 1'b1, 3'b011, link, 1'b0, 1'b0, 4'h0, 5'h0);
    step();
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 3'b011, 38'h55, 1'b0, 1'b0, 4'h0, 5'h0);
    step();
    step();
    idle();
    checks++; if (ras_index !== 4'd0) begin errors++; $display("FAIL reset_index got=%0d exp=0", ras_index); end
    checks++; if (ras_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", ras_count); end
    checks++; if (ret_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", ret_valid); end
    checks++; if (ret_pc38 !== 38'h0) begin errors++; $display("FAIL reset_pc got=%0h exp=0", ret_pc38); end
  endtask

  task automatic test_push_pop();
    logic [37:0] exp_pc [3];
    exp_pc[0] = 38'h300; exp_pc[1] = 38'h200; exp_pc[2] = 38'h100;
    do_reset();
    push(38'h100); push(38'h200); push(38'h300);
    idle();
    checks++; if (ras_count !== 5'd3) begin errors++; $display("FAIL pp_count got=%0d exp=3", ras_count); end
    checks++; if (ras_index !== 4'd3) begin errors++; $display("FAIL pp_index got=%0d exp=3", ras_index); end
    checks++; if (ret_pc38 !== 38'h300) begin errors++; $display("FAIL pp_top got=%0h exp=300", ret_pc38); end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 3'b100, 38'h0, 1'b0, 1'b0, 4'h0, 5'h0);
      #1;
      checks++; if (ret_pc38 !== exp_pc[k]) begin errors++; $display("FAIL pp_ret%0d got=%0h exp=%0h", k, ret_pc38, exp_pc[k]); end
      step();
    end
    idle();
    checks++; if (ras_count !== 5'd0) begin errors++; $display("FAIL pp_end_count got=%0d exp=0", ras_count); end
    checks++; if (ret_valid !== 1'b0) begin errors++; $display("FAIL pp_end_valid got=%0b exp=0", ret_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 1; k <= 17; k++) push(38'(k));
    idle();
    checks++; if (ras_count !== 5'd16) begin errors++; $display("FAIL of_count got=%0d exp=16", ras_count); end
    checks++; if (ras_index !== 4'd1) begin errors++; $display("FAIL of_index got=%0d exp=1", ras_index); end
    checks++; if (ret_pc38 !== 38'd17) begin errors++; $display("FAIL of_top got=%0d exp=17", ret_pc38); end
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b1, 3'b100, 38'h0, 1'b0, 1'b0, 4'h0, 5'h0);
      #1;
      checks++; if (ret_pc38 !== 38'(17 - k)) begin errors++; $display("FAIL of_ret%0d got=%0d exp=%0d", k, ret_pc38, 17 - k); end
      step();
    end
    checks++; if (ras_count !== 5'd0) begin errors++; $display("FAIL of_drain_count got=%0d exp=0", ras_count); end
    drive(1'b0, 1'b1, 3'b100, 38'h0, 1'b0, 1'b0, 4'h0, 5'h0);
    step();
    idle();
    checks++; if (ras_index !== 4'd1) begin errors++; $display("FAIL uf_index got=%0d exp=1", ras_index); end
    checks++; if (ras_count !== 5'd0) begin errors++; $display("FAIL uf_count got=%0d exp=0", ras_count); end
  endtask

  task automatic test_ret_l();
    do_reset();
    drive(1'b0, 1'b1, 3'b101, 38'hABC, 1'b0, 1'b0, 4'h0, 5'h0);
    step();
    idle();
    checks++; if (ras_count !== 5'd1) begin errors++; $display("FAIL retl_count got=%0d exp=1", ras_count); end
    checks++; if (ras_index !== 4'd0) begin errors++; $display("FAIL retl_index got=%0d exp=0", ras_index); end
    checks++; if (ret_pc38 !== 38'hABC) begin errors++; $display("FAIL retl_pc got=%0h exp=abc", ret_pc38); end
    push(38'h111);
    drive(1'b0, 1'b1, 3'b101, 38'h222, 1'b0, 1'b0, 4'h0, 5'h0);
    #1;
    checks++; if (ret_pc38 !== 38'h111) begin errors++; $display("FAIL retl_old got=%0h exp=111", ret_pc38); end
    step();
    idle();
    checks++; if (ras_count !== 5'd2) begin errors++; $display("FAIL retl2_count got=%0d exp=2", ras_count); end
    checks++; if (ret_pc38 !== 38'h222) begin errors++; $display("FAIL retl2_pc got=%0h exp=222", ret_pc38); end
    drive(1'b0, 1'b1, 3'b100, 38'h0, 1'b0, 1'b0, 4'h0, 5'h0);
    step();
    idle();
    checks++; if (ret_pc38 !== 38'hABC) begin errors++; $display("FAIL retl2_below got=%0h exp=abc", ret_pc38); end
  endtask

  task automatic test_restart();
    do_reset();
    for (int k = 0; k < 5; k++) push(38'h10 + 38'(k));
    drive(1'b0, 1'b1, 3'b011, 38'hDEAD, 1'b0, 1'b1, 4'd2, 5'd2);
    step();
    idle();
    checks++; if (ras_index !== 4'd2) begin errors++; $display("FAIL rs_index got=%0d exp=2", ras_index); end
    checks++; if (ras_count !== 5'd2) begin errors++; $display("FAIL rs_count got=%0d exp=2", ras_count); end
    checks++; if (ret_pc38 !== 38'h11) begin errors++; $display("FAIL rs_pc got=%0h exp=11", ret_pc38); end
    // Entry 6 would have received the dropped push.
    drive(1'b0, 1'b0, 3'b000, 38'h0, 1'b0, 1'b1, 4'd6, 5'd1);
    step();
    idle();
    checks++; if (ret_pc38 !== 38'h0) begin errors++; $display("FAIL rs_nowrite got=%0h exp=0", ret_pc38); end
    drive(1'b0, 1'b0, 3'b000, 38'h0, 1'b0, 1'b1, 4'd3, 5'd20);
    step();
    idle();
    checks++; if (ras_count !== 5'd16) begin errors++; $display("FAIL rs_clamp got=%0d exp=16", ras_count); end
    checks++; if (ras_index !== 4'd3) begin errors++; $display("FAIL rs_clamp_index got=%0d exp=3", ras_index); end
  endtask

  task automatic test_stall();
    do_reset();
    push(38'hA1); push(38'hA2); push(38'hA3);
    drive(1'b0, 1'b1, 3'b100, 38'h0, 1'b1, 1'b0, 4'h0, 5'h0);
    step();
    step();
    idle();
    checks++; if (ras_count !== 5'd3) begin errors++; $display("FAIL st_count got=%0d exp=3", ras_count); end
    checks++; if (ras_index !== 4'd3) begin errors++; $display("FAIL st_index got=%0d exp=3", ras_index); end
    checks++; if (ret_pc38 !== 38'hA3) begin errors++; $display("FAIL st_pc got=%0h exp=a3", ret_pc38); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0,
            3'($urandom_range(0, 7)),
            {6'($urandom), 32'($urandom)},
            ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
            ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0,
            4'($urandom_range(0, 15)),
            5'($urandom_range(0, 31)));
      step();
      checks++;
      if (ras_index !== 4'(m_sp) || ras_count !== 5'(m_cnt) ||
          ret_valid !== (m_cnt != 0) || ret_pc38 !== m_stack[m_sp]) begin
        errors++;
        $display("FAIL rnd_cycle%0d got idx=%0d cnt=%0d v=%0b pc=%0h exp idx=%0d cnt=%0d pc=%0h",
                 n, ras_index, ras_count, ret_valid, ret_pc38, m_sp, m_cnt, m_stack[m_sp]);
      end
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_stack[i] = 38'h0;
    m_sp = 0;
    m_cnt = 0;
    idle();
    #1;
    test_reset();
    test_push_pop();
    test_overflow();
    test_ret_l();
    test_restart();
    test_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
